// File: rtl/half_adder.sv
// Half adder: combinational sum/carry plus a 1-cycle registered copy, no backpressure.
// Define HALF_ADDER_STATS_EN to build the saturating op/carry statistics counters.
module half_adder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  input  logic             stat_clr,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  logic w_sum;
  logic w_carry;
  logic r_sum_q;
  logic r_carry_q;
  logic r_out_valid;

  assign w_sum   = a ^ b;
  assign w_carry = a & b;
  assign sum     = w_sum;
  assign carry   = w_carry;

  // Result registers only load on accepted cycles, so idle X on a/b never reaches state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q     <= 1'b0;
      r_carry_q   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q   <= w_sum;
        r_carry_q <= w_carry;
      end
    end
  end

  assign sum_q     = r_sum_q;
  assign carry_q   = r_carry_q;
  assign out_valid = r_out_valid;

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_op_cnt;
  logic [CNT_W-1:0] r_carry_cnt;

  // Clear takes priority over a same-cycle accepted operation; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt    <= '0;
      r_carry_cnt <= '0;
    end else if (stat_clr) begin
      r_op_cnt    <= '0;
      r_carry_cnt <= '0;
    end else if (in_valid) begin
      if (r_op_cnt != CNT_MAX) begin
        r_op_cnt <= r_op_cnt + CNT_ONE;
      end
      if (w_carry && (r_carry_cnt != CNT_MAX)) begin
        r_carry_cnt <= r_carry_cnt + CNT_ONE;
      end
    end
  end

  assign op_cnt    = r_op_cnt;
  assign carry_cnt = r_carry_cnt;
`else
  logic w_unused;

  assign w_unused  = stat_clr;
  assign op_cnt    = '0;
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: directed vectors, expected results queued at issue time.
module tb_half_adder;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       in_valid;
  logic       stat_clr;
  logic       sum;
  logic       carry;
  logic       sum_q;
  logic       carry_q;
  logic       out_valid;
  logic [15:0] op_cnt;
  logic [15:0] carry_cnt;
  logic       sum2;
  logic       carry2;
  logic       sum_q2;
  logic       carry_q2;
  logic       out_valid2;
  logic [1:0] op_cnt2;
  logic [1:0] carry_cnt2;

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int popped = 0;

  logic [1:0] sb[$];

  // Bench-side counter model, 16-bit and 2-bit instances.
  int m_op16 = 0;
  int m_cr16 = 0;
  int m_op2  = 0;
  int m_cr2  = 0;

  half_adder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .stat_clr(stat_clr),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q), .out_valid(out_valid),
    .op_cnt(op_cnt), .carry_cnt(carry_cnt)
  );

  half_adder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .stat_clr(stat_clr),
    .sum(sum2), .carry(carry2), .sum_q(sum_q2), .carry_q(carry_q2), .out_valid(out_valid2),
    .op_cnt(op_cnt2), .carry_cnt(carry_cnt2)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected result for every presented output.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        chk("result_sum_carry", {30'd0, sum_q, carry_q}, {30'd0, sb[0]});
        chk("result_small_inst", {30'd0, sum_q2, carry_q2}, {30'd0, sb[0]});
        void'(sb.pop_front());
        popped++;
      end
    end
  end

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    m_op16 = 0; m_cr16 = 0; m_op2 = 0; m_cr2 = 0;
  endtask

  task automatic op(input logic ia, input logic ib, input logic clr);
    @(posedge clk);
    #1;
    a = ia; b = ib; in_valid = 1'b1; stat_clr = clr;
    sb.push_back({ia ^ ib, ia & ib});
    pushed++;
    if (clr) begin
      model_clear();
    end else begin
      m_op16 = sat_inc(m_op16, 65535);
      m_op2  = sat_inc(m_op2, 3);
      if (ia && ib) begin
        m_cr16 = sat_inc(m_cr16, 65535);
        m_cr2  = sat_inc(m_cr2, 3);
      end
    end
  endtask

  task automatic idle(input logic clr);
    @(posedge clk);
    #1;
    a = 1'bx; b = 1'bx; in_valid = 1'b0; stat_clr = clr;
    if (clr) model_clear();
  endtask

  task automatic chk_counters(input string name);
`ifdef HALF_ADDER_STATS_EN
    chk({name, "_op16"}, {16'd0, op_cnt},     m_op16);
    chk({name, "_cr16"}, {16'd0, carry_cnt},  m_cr16);
    chk({name, "_op2"},  {30'd0, op_cnt2},    m_op2);
    chk({name, "_cr2"},  {30'd0, carry_cnt2}, m_cr2);
`else
    chk({name, "_op16"}, {16'd0, op_cnt},     32'd0);
    chk({name, "_cr16"}, {16'd0, carry_cnt},  32'd0);
    chk({name, "_op2"},  {30'd0, op_cnt2},    32'd0);
    chk({name, "_cr2"},  {30'd0, carry_cnt2}, 32'd0);
`endif
  endtask

  logic [1:0] comb_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] comb_exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

  initial begin
    clk_en = 1'b0; rst_n = 1'b0; a = 1'b0; b = 1'b0; in_valid = 1'b0; stat_clr = 1'b0;

    // Combinational truth table with no clock and reset held.
    for (int i = 0; i < 4; i++) begin
      {a, b} = comb_in[i];
      #50;
      chk("comb_sum_carry", {30'd0, sum, carry}, {30'd0, comb_exp[i]});
    end
    chk("reset_regs", {29'd0, sum_q, carry_q, out_valid}, 32'd0);
    chk_counters("reset");

    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single 11 op, then an idle cycle that must hold the result.
    op(1'b1, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_hold", {30'd0, sum_q, carry_q}, 32'd1);

    // Clear on an idle cycle, then 4 back-to-back ops.
    idle(1'b1);
    idle(1'b0);
    chk_counters("after_idle_clr");
    op(1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0);
    op(1'b1, 1'b0, 1'b0);
    op(1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk_counters("four_ops");

    // Clear wins over a same-cycle accepted op; the result is still produced.
    op(1'b1, 1'b0, 1'b1);
    idle(1'b0);
    chk_counters("clr_with_valid");

    // Saturation of the 2-bit instance.
    for (int i = 0; i < 5; i++) op(1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk_counters("saturate");

    // Asynchronous reset while a result is presented.
    op(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1;
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_regs", {29'd0, sum_q, carry_q, out_valid}, 32'd0);
    chk("async_reset_small", {29'd0, sum_q2, carry_q2, out_valid2}, 32'd0);
    model_clear();
    chk_counters("async_reset");
    sb.delete();
    pushed--;
    chk("comb_during_reset", {30'd0, sum, carry}, {30'd0, a ^ b, a & b});
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Capture resumes after reset.
    op(1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk_counters("post_reset");
    repeat (3) idle(1'b0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("results_seen", popped, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the statistics counters, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port a, input, 1 bit: addend A.
REQ-005 SHALL have port b, input, 1 bit: addend B.
REQ-006 SHALL have port in_valid, input, 1 bit: a/b are qualified this cycle.
REQ-007 SHALL have port stat_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-008 SHALL have port sum, output, 1 bit: combinational a XOR b.
REQ-009 SHALL have port carry, output, 1 bit: combinational a AND b.
REQ-010 SHALL have port sum_q, output, 1 bit: registered sum.
REQ-011 SHALL have port carry_q, output, 1 bit: registered carry.
REQ-012 SHALL have port out_valid, output, 1 bit: sum_q/carry_q are valid.
REQ-013 SHALL have port op_cnt, output, CNT_W bits: count of accepted operations.
REQ-014 SHALL have port carry_cnt, output, CNT_W bits: count of accepted operations with carry=1.

Function
REQ-015 sum/carry SHALL follow the truth table with zero cycle latency, independent of clk, rst_n and in_valid: 00->0/0, 01->1/0, 10->1/0, 11->0/1.
REQ-016 On a rising clk edge with in_valid=1, sum_q/carry_q SHALL load a^b and a&b, and out_valid SHALL be 1 the following cycle (latency 1).
REQ-017 On a rising clk edge with in_valid=0, sum_q/carry_q SHALL hold their values and out_valid SHALL be 0.
REQ-018 Back-to-back in_valid=1 cycles SHALL each produce a result; there is no backpressure.
REQ-019 op_cnt SHALL increment by 1 per accepted operation (in_valid=1 at an edge).
REQ-020 carry_cnt SHALL increment by 1 per accepted operation with a=b=1.
REQ-021 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 stat_clr=1 at an edge SHALL zero both counters; if in_valid=1 in the same cycle, the clear wins and that operation is not counted; sum_q/carry_q/out_valid still update per REQ-016.
REQ-023 X on a or b while in_valid=0 SHALL not affect any registered state.

Reset
REQ-024 rst_n=0 SHALL asynchronously force sum_q=0, carry_q=0, out_valid=0, op_cnt=0 and carry_cnt=0.
REQ-025 Registers SHALL resume capture on the first rising clk edge after rst_n deasserts.
REQ-026 Reset asserted mid-stream SHALL discard any in-flight result.
REQ-027 sum/carry SHALL remain combinational and valid during reset.

Configuration
REQ-028 Macro HALF_ADDER_STATS_EN defined: op_cnt/carry_cnt SHALL operate per REQ-019..REQ-022.
REQ-029 Macro HALF_ADDER_STATS_EN undefined: no counter registers SHALL be implemented, op_cnt and carry_cnt SHALL be constant 0, and stat_clr SHALL be ignored; all other behaviour is unchanged.

Verification
REQ-030 Apply {a,b}=00,01,10,11 for 50 ns each with no clock -> sum/carry = 0/0, 1/0, 1/0, 0/1 at each step.
REQ-031 After reset, in_valid=1 with a=1,b=1 for one edge -> next cycle sum_q=0, carry_q=1, out_valid=1; following cycle with in_valid=0 -> out_valid=0, sum_q/carry_q held.
REQ-032 With stats enabled, 4 accepted operations 00,01,10,11 -> op_cnt=4, carry_cnt=1; then stat_clr=1 together with in_valid=1 -> both counters 0.
REQ-033 With CNT_W=2 and stats enabled, 5 accepted operations of 11 -> op_cnt=3 and carry_cnt=3, both saturated.
REQ-034 Assert rst_n=0 between clock edges while out_valid=1 -> all registered outputs 0 immediately, without waiting for a clock edge.
REQ-035 Build without HALF_ADDER_STATS_EN and run 4 operations -> op_cnt=0, carry_cnt=0, and sum_q/carry_q correct.
